// File: rtl/nf10_upb_output_demux_if.sv
// AXI-Stream bundle with the learning-switch tuser fields; N lanes side by side.
// The demux uses N=1 on its input and N=NUM_PORTS on its output.
interface nf10_upb_output_demux_if #(
    parameter int unsigned N = 1
);
    logic [N*256-1:0] tdata;
    logic [N*32-1:0]  tkeep;
    logic [N-1:0]     tvalid;
    logic [N-1:0]     tlast;
    logic [N*3-1:0]   tuser_in_port;
    logic [N*3-1:0]   tuser_in_vport;
    logic [N*8-1:0]   tuser_out_port;
    logic [N*8-1:0]   tuser_out_vport;
    logic [N*14-1:0]  tuser_packet_length;
    logic [N-1:0]     tready;

    modport master (
        output tdata, tkeep, tvalid, tlast,
        output tuser_in_port, tuser_in_vport, tuser_out_port, tuser_out_vport,
        output tuser_packet_length,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tvalid, tlast,
        input  tuser_in_port, tuser_in_vport, tuser_out_port, tuser_out_vport,
        input  tuser_packet_length,
        output tready
    );
endinterface

// File: rtl/nf10_upb_output_demux.sv
// Fans the learning-switch output stream out to the ports named in the tuser
// out_port mask; multicast beats advance in lockstep, empty-mask packets are dropped.
module nf10_upb_output_demux #(
    parameter int unsigned NUM_PORTS   = 5,
    parameter int unsigned DMA_PORT_ID = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    nf10_upb_output_demux_if.slave        s_axis,
    nf10_upb_output_demux_if.master       m_axis,
    output logic [31:0]                   drop_count
);
    localparam int unsigned DW = 256;
    localparam int unsigned KW = 32;
    localparam int unsigned PW = 3;
    localparam int unsigned VW = 8;
    localparam int unsigned LW = 14;
    localparam int unsigned CW = 32;

    typedef enum logic [1:0] {
        ST_HEAD = 2'd0,
        ST_BODY = 2'd1,
        ST_DROP = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [NUM_PORTS-1:0]   head_mask, eff_mask, port_free, load;
    logic [NUM_PORTS-1:0]   valid_q, valid_d;
    logic [NUM_PORTS-1:0]   pkt_mask_q, pkt_mask_d;
    logic                   tready_c, accept_c, hdr_latch_c, drop_inc_c;
    logic [CW-1:0]          drop_count_q, drop_count_d;

    // Header fields held for the body of the current packet
    logic [PW-1:0]          in_port_q, in_vport_q;
    logic [VW-1:0]          out_vport_q;
    logic [LW-1:0]          len_q;
    logic [PW-1:0]          hdr_in_port, hdr_in_vport;
    logic [VW-1:0]          hdr_out_vport;
    logic [LW-1:0]          hdr_len;

    assign head_mask = s_axis.tuser_out_port[NUM_PORTS-1:0];
    assign port_free = ~valid_q | m_axis.tready;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_HEAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HEAD: begin
                if (accept_c && !s_axis.tlast[0]) begin
                    state_d = (head_mask == '0) ? ST_DROP : ST_BODY;
                end
            end
            ST_BODY, ST_DROP: begin
                if (accept_c && s_axis.tlast[0]) begin
                    state_d = ST_HEAD;
                end
            end
            default: state_d = ST_HEAD;
        endcase
    end

    // Output decode: ready is the AND of every selected port being free
    always_comb begin
        eff_mask    = '0;
        tready_c    = 1'b0;
        accept_c    = 1'b0;
        load        = '0;
        hdr_latch_c = 1'b0;
        drop_inc_c  = 1'b0;
        case (state_q)
            ST_HEAD: eff_mask = head_mask;
            ST_BODY: eff_mask = pkt_mask_q;
            default: eff_mask = '0;
        endcase
        tready_c    = (state_q == ST_DROP) || (&(~eff_mask | port_free));
        accept_c    = s_axis.tvalid[0] & tready_c;
        load        = accept_c ? eff_mask : '0;
        hdr_latch_c = accept_c && (state_q == ST_HEAD) && (head_mask != '0);
        drop_inc_c  = accept_c && s_axis.tlast[0] &&
                      (((state_q == ST_HEAD) && (head_mask == '0)) || (state_q == ST_DROP));
    end

    assign s_axis.tready = tready_c;

    assign hdr_in_port   = (state_q == ST_HEAD) ? s_axis.tuser_in_port         : in_port_q;
    assign hdr_in_vport  = (state_q == ST_HEAD) ? s_axis.tuser_in_vport        : in_vport_q;
    assign hdr_out_vport = (state_q == ST_HEAD) ? s_axis.tuser_out_vport       : out_vport_q;
    assign hdr_len       = (state_q == ST_HEAD) ? s_axis.tuser_packet_length   : len_q;

    assign pkt_mask_d   = hdr_latch_c ? head_mask : pkt_mask_q;
    assign valid_d      = load | (valid_q & ~m_axis.tready);
    assign drop_count_d = (drop_inc_c && (drop_count_q != '1)) ? drop_count_q + CW'(1) : drop_count_q;

    // Control registers that must come out of reset in a known state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_mask_q   <= '0;
            valid_q      <= '0;
            drop_count_q <= '0;
        end else begin
            pkt_mask_q   <= pkt_mask_d;
            valid_q      <= valid_d;
            drop_count_q <= drop_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (hdr_latch_c) begin
            in_port_q   <= s_axis.tuser_in_port;
            in_vport_q  <= s_axis.tuser_in_vport;
            out_vport_q <= s_axis.tuser_out_vport;
            len_q       <= s_axis.tuser_packet_length;
        end
    end

    assign drop_count    = drop_count_q;
    assign m_axis.tvalid = valid_q;

    // Per-port one-beat output registers
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        logic [DW-1:0] data_q;
        logic [KW-1:0] keep_q;
        logic          last_q;
        logic [PW-1:0] ip_q, iv_q;
        logic [LW-1:0] plen_q;

        always_ff @(posedge clk) begin
            if (load[i]) begin
                data_q <= s_axis.tdata;
                keep_q <= s_axis.tkeep;
                last_q <= s_axis.tlast[0];
                ip_q   <= hdr_in_port;
                iv_q   <= hdr_in_vport;
                plen_q <= hdr_len;
            end
        end

        assign m_axis.tdata[i*DW +: DW]               = data_q;
        assign m_axis.tkeep[i*KW +: KW]               = keep_q;
        assign m_axis.tlast[i]                        = last_q;
        assign m_axis.tuser_in_port[i*PW +: PW]       = ip_q;
        assign m_axis.tuser_in_vport[i*PW +: PW]      = iv_q;
        assign m_axis.tuser_packet_length[i*LW +: LW] = plen_q;
        assign m_axis.tuser_out_port[i*VW +: VW]      = VW'(1) << i;

        // Only the DMA port carries the vport mask onward
        if (i == DMA_PORT_ID) begin : g_dma
            logic [VW-1:0] ov_q;
            always_ff @(posedge clk) begin
                if (load[i]) begin
                    ov_q <= hdr_out_vport;
                end
            end
            assign m_axis.tuser_out_vport[i*VW +: VW] = ov_q;
        end else begin : g_phys
            assign m_axis.tuser_out_vport[i*VW +: VW] = '0;
        end
    end

    if (NUM_PORTS < 8) begin : g_unused_mask
        logic unused_mask_bits;
        assign unused_mask_bits = ^s_axis.tuser_out_port[7:NUM_PORTS];
    end
endmodule

// File: tb/tb_nf10_upb_output_demux.sv
// Directed scoreboard bench for nf10_upb_output_demux (5 ports, DMA on port 4).
module tb_nf10_upb_output_demux;
    localparam int unsigned NP  = 5;
    localparam int unsigned DMA = 4;

    typedef struct packed {
        logic [255:0] data;
        logic [31:0]  keep;
        logic         last;
        logic [2:0]   ip;
        logic [2:0]   iv;
        logic [7:0]   op;
        logic [7:0]   ov;
        logic [13:0]  len;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] drop_count;

    nf10_upb_output_demux_if #(.N(1))  s_if ();
    nf10_upb_output_demux_if #(.N(NP)) m_if ();

    nf10_upb_output_demux #(.NUM_PORTS(NP), .DMA_PORT_ID(DMA)) dut (
        .clk        (clk),
        .reset      (reset),
        .s_axis     (s_if),
        .m_axis     (m_if),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    int    n_cmp = 0;
    int    n_bad = 0;
    int    pkt_id = 0;
    beat_t exp_q [NP][$];
    beat_t prev [NP];
    bit    hold_chk [NP];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic beat_t get_beat(input int i);
        beat_t b;
        b.data = m_if.tdata[i*256 +: 256];
        b.keep = m_if.tkeep[i*32 +: 32];
        b.last = m_if.tlast[i];
        b.ip   = m_if.tuser_in_port[i*3 +: 3];
        b.iv   = m_if.tuser_in_vport[i*3 +: 3];
        b.op   = m_if.tuser_out_port[i*8 +: 8];
        b.ov   = m_if.tuser_out_vport[i*8 +: 8];
        b.len  = m_if.tuser_packet_length[i*14 +: 14];
        return b;
    endfunction

    // Monitor: pops the scoreboard on every output handshake, checks hold stability
    initial begin
        beat_t got, e;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NP; i++) begin
                if (reset) begin
                    hold_chk[i] = 1'b0;
                end else begin
                    got = get_beat(i);
                    if (hold_chk[i]) begin
                        n_cmp++;
                        if (got !== prev[i]) begin
                            n_bad++;
                            $display("FAIL hold_stable port%0d: got=%h want=%h", i, got, prev[i]);
                        end
                    end
                    hold_chk[i] = m_if.tvalid[i] && !m_if.tready[i];
                    prev[i] = got;
                    if (m_if.tvalid[i] && m_if.tready[i]) begin
                        n_cmp++;
                        if (exp_q[i].size() == 0) begin
                            n_bad++;
                            $display("FAIL unexpected_beat port%0d: got=%h want=none", i, got);
                        end else begin
                            e = exp_q[i].pop_front();
                            if (got !== e) begin
                                n_bad++;
                                $display("FAIL beat port%0d: got=%h want=%h", i, got, e);
                            end
                        end
                    end
                end
            end
        end
    end

    // Drives nb beats of a total-beat packet; body beats carry scrambled tuser
    task automatic send_pkt(input int nb, input int total, input logic [7:0] op, input logic [7:0] ov,
                            input logic [2:0] ip, input logic [2:0] iv, input logic [13:0] len,
                            input logic [NP-1:0] exp_mask, input bit chk_v, output int waits);
        beat_t e;
        logic [255:0] d;
        logic [31:0]  k;
        logic         l;
        bit           acc;
        waits = 0;
        pkt_id++;
        for (int b = 0; b < nb; b++) begin
            d = {8{pkt_id[15:0], 16'(b)}};
            l = (b == total - 1);
            k = l ? 32'h0000_FFFF : 32'hFFFF_FFFF;
            s_if.tdata                = d;
            s_if.tkeep                = k;
            s_if.tlast                = l;
            s_if.tuser_out_port       = (b == 0) ? op  : ~op;
            s_if.tuser_out_vport      = (b == 0) ? ov  : ~ov;
            s_if.tuser_in_port        = (b == 0) ? ip  : ~ip;
            s_if.tuser_in_vport       = (b == 0) ? iv  : ~iv;
            s_if.tuser_packet_length  = (b == 0) ? len : ~len;
            s_if.tvalid               = 1'b1;
            for (int i = 0; i < NP; i++) begin
                if (exp_mask[i]) begin
                    e.data = d; e.keep = k; e.last = l;
                    e.ip = ip; e.iv = iv; e.len = len;
                    e.op = 8'(1) << i;
                    e.ov = (i == DMA) ? ov : 8'h00;
                    exp_q[i].push_back(e);
                end
            end
            acc = 1'b0;
            for (int t = 0; t < 100; t++) begin
                @(negedge clk);
                if (s_if.tready[0]) begin
                    acc = 1'b1;
                    break;
                end
                waits++;
            end
            if (!acc) check("accept_timeout", 64'd0, 64'd1);
            @(posedge clk);
            #1;
            if (chk_v) check("valid_after_accept", 64'(m_if.tvalid), 64'(exp_mask));
            s_if.tvalid = 1'b0;
        end
    endtask

    initial begin
        #400000;
        n_bad++;
        $display("FAIL watchdog: got=timeout want=finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        reset       = 1'b1;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tkeep  = '0;
        s_if.tlast  = 1'b0;
        s_if.tuser_in_port = '0; s_if.tuser_in_vport = '0;
        s_if.tuser_out_port = '0; s_if.tuser_out_vport = '0;
        s_if.tuser_packet_length = '0;
        m_if.tready = '1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_tvalid", 64'(m_if.tvalid), 64'd0);
        check("reset_drop_count", 64'(drop_count), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Unicast 3 beats to port 2, no stall expected
        send_pkt(3, 3, 8'h04, 8'h00, 3'd1, 3'd2, 14'd90, 5'b00100, 1'b1, w);
        check("unicast_waits", 64'(w), 64'd0);

        // Broadcast with port 3 stalled for 4 cycles after the first beat
        m_if.tready[3] = 1'b0;
        fork
            begin
                send_pkt(3, 3, 8'hFF, 8'h00, 3'd3, 3'd1, 14'd80, 5'b11111, 1'b0, w);
                check("bcast_waits", 64'(w), 64'd4);
            end
            begin
                for (int t = 0; t < 100; t++) begin
                    @(negedge clk);
                    if (s_if.tvalid[0] && s_if.tready[0]) break;
                end
                @(posedge clk);
                for (int c = 0; c < 4; c++) begin
                    @(negedge clk);
                    check("stall_tready_low", 64'(s_if.tready[0]), 64'd0);
                end
                @(posedge clk); #1;
                m_if.tready[3] = 1'b1;
            end
        join
        repeat (2) @(posedge clk); #1;

        // Empty-mask 2-beat packet is dropped, then a single-beat empty packet
        check("drop_count_before", 64'(drop_count), 64'd0);
        send_pkt(2, 2, 8'h00, 8'h00, 3'd0, 3'd0, 14'd60, 5'b00000, 1'b1, w);
        check("drop_count_multi", 64'(drop_count), 64'd1);
        send_pkt(1, 1, 8'hE0, 8'h00, 3'd0, 3'd0, 14'd60, 5'b00000, 1'b1, w);
        check("drop_count_upper_bits", 64'(drop_count), 64'd2);
        send_pkt(1, 1, 8'h01, 8'h00, 3'd5, 3'd6, 14'd64, 5'b00001, 1'b1, w);

        // Back-to-back single-beat packets
        send_pkt(1, 1, 8'h01, 8'h00, 3'd1, 3'd0, 14'd10, 5'b00001, 1'b1, w);
        check("b2b_waits0", 64'(w), 64'd0);
        send_pkt(1, 1, 8'h02, 8'h00, 3'd2, 3'd0, 14'd20, 5'b00010, 1'b1, w);
        check("b2b_waits1", 64'(w), 64'd0);
        send_pkt(1, 1, 8'h01, 8'h00, 3'd3, 3'd0, 14'd30, 5'b00001, 1'b1, w);
        check("b2b_waits2", 64'(w), 64'd0);

        // vport routing: only the DMA port carries out_vport
        send_pkt(2, 2, 8'h11, 8'h06, 3'd4, 3'd5, 14'd100, 5'b10001, 1'b1, w);
        repeat (2) @(posedge clk); #1;

        // Reset while beat 2 of a 4-beat packet is being presented
        send_pkt(1, 4, 8'h02, 8'h00, 3'd1, 3'd1, 14'd128, 5'b00010, 1'b1, w);
        s_if.tdata  = {8{32'hDEAD_0002}};
        s_if.tlast  = 1'b0;
        s_if.tvalid = 1'b1;
        #2;
        reset = 1'b1;
        s_if.tvalid = 1'b0;
        for (int i = 0; i < NP; i++) exp_q[i].delete();
        #1;
        check("midreset_tvalid", 64'(m_if.tvalid), 64'd0);
        check("midreset_drop_count", 64'(drop_count), 64'd0);
        repeat (2) @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        send_pkt(2, 2, 8'h08, 8'h00, 3'd2, 3'd3, 14'd50, 5'b01000, 1'b1, w);
        check("post_reset_drop_count", 64'(drop_count), 64'd0);

        repeat (4) @(posedge clk); #1;
        for (int i = 0; i < NP; i++) check($sformatf("queue_empty_port%0d", i), 64'(exp_q[i].size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
